// File: rtl/tlul_axil_master_bridge.sv
// rtl/tlul_axil_master_bridge.sv - TL-UL slave to AXI-lite master bridge, one transaction in flight.
// Optional TLUL_AXIL_BRIDGE_ERR_RESP_EN: fold AXI bresp/rresp into tl_d_error_o.
module tlul_axil_master_bridge #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int tl_source_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           tl_a_valid_i,
    output logic                           tl_a_ready_o,
    input  logic [2:0]                     tl_a_opcode_i,
    input  logic [1:0]                     tl_a_size_i,
    input  logic [tl_source_width_p-1:0]   tl_a_source_i,
    input  logic [axil_addr_width_p-1:0]   tl_a_address_i,
    input  logic [axil_data_width_p/8-1:0] tl_a_mask_i,
    input  logic [axil_data_width_p-1:0]   tl_a_data_i,

    output logic                           tl_d_valid_o,
    input  logic                           tl_d_ready_i,
    output logic [2:0]                     tl_d_opcode_o,
    output logic [1:0]                     tl_d_size_o,
    output logic [tl_source_width_p-1:0]   tl_d_source_o,
    output logic [axil_data_width_p-1:0]   tl_d_data_o,
    output logic                           tl_d_error_o,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr,
    output logic [2:0]                     m_axil_awprot,
    output logic                           m_axil_awvalid,
    input  logic                           m_axil_awready,
    output logic [axil_data_width_p-1:0]   m_axil_wdata,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb,
    output logic                           m_axil_wvalid,
    input  logic                           m_axil_wready,
    input  logic [1:0]                     m_axil_bresp,
    input  logic                           m_axil_bvalid,
    output logic                           m_axil_bready,
    output logic [axil_addr_width_p-1:0]   m_axil_araddr,
    output logic [2:0]                     m_axil_arprot,
    output logic                           m_axil_arvalid,
    input  logic                           m_axil_arready,
    input  logic [axil_data_width_p-1:0]   m_axil_rdata,
    input  logic [1:0]                     m_axil_rresp,
    input  logic                           m_axil_rvalid,
    output logic                           m_axil_rready
);

    localparam int strb_w = axil_data_width_p / 8;

    typedef enum logic [2:0] {IDLE, WRITE, B_WAIT, READ, R_WAIT, RESP} state_e;

    state_e                         state_q, state_d;
    logic                           a_ready_q, a_ready_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic [2:0]                     opcode_q, opcode_d;
    logic [1:0]                     size_q, size_d;
    logic [tl_source_width_p-1:0]   source_q, source_d;
    logic [axil_addr_width_p-1:0]   addr_q, addr_d;
    logic [axil_data_width_p-1:0]   data_q, data_d;
    logic [strb_w-1:0]              mask_q, mask_d;
    logic [axil_data_width_p-1:0]   rdata_q, rdata_d;
    logic [1:0]                     resp_q, resp_d;
    logic                           illegal_q, illegal_d;
    logic                           a_fire;

    assign a_fire = tl_a_valid_i & a_ready_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    opcode_d  = tl_a_opcode_i;
                    size_d    = tl_a_size_i;
                    source_d  = tl_a_source_i;
                    addr_d    = tl_a_address_i;
                    data_d    = tl_a_data_i;
                    mask_d    = tl_a_mask_i;
                    resp_d    = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    illegal_d = 1'b0;
                    if (tl_a_opcode_i == 3'd4) begin
                        state_d = READ;
                    end else if (tl_a_opcode_i == 3'd0 || tl_a_opcode_i == 3'd1) begin
                        state_d = WRITE;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; both must have fired before the B phase.
                aw_done_d = aw_done_q | m_axil_awready;
                w_done_d  = w_done_q | m_axil_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = B_WAIT;
                end
            end
            B_WAIT: begin
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    state_d = RESP;
                end
            end
            READ: begin
                if (m_axil_arready) begin
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tl_d_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        a_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            a_ready_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_ready_q <= a_ready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Transaction payload is only observed behind a valid, so it carries no reset.
    always_ff @(posedge clk_i) begin
        opcode_q  <= opcode_d;
        size_q    <= size_d;
        source_q  <= source_d;
        addr_q    <= addr_d;
        data_q    <= data_d;
        mask_q    <= mask_d;
        rdata_q   <= rdata_d;
        resp_q    <= resp_d;
        illegal_q <= illegal_d;
    end

    assign tl_a_ready_o   = a_ready_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = (state_q == WRITE) & ~aw_done_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = (opcode_q == 3'd0) ? {strb_w{1'b1}} : mask_q;
    assign m_axil_wvalid  = (state_q == WRITE) & ~w_done_q;
    assign m_axil_bready  = (state_q == B_WAIT);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state_q == READ);
    assign m_axil_rready  = (state_q == R_WAIT);

    assign tl_d_valid_o   = (state_q == RESP);
    assign tl_d_opcode_o  = {2'b00, opcode_q == 3'd4};
    assign tl_d_size_o    = size_q;
    assign tl_d_source_o  = source_q;
    assign tl_d_data_o    = (opcode_q == 3'd4) ? rdata_q : '0;

`ifdef TLUL_AXIL_BRIDGE_ERR_RESP_EN
    assign tl_d_error_o   = illegal_q | (resp_q != 2'b00);
`else
    logic unused_resp;
    assign unused_resp    = ^resp_q;
    assign tl_d_error_o   = illegal_q;
`endif

endmodule

// File: tb/tb_tlul_axil_master_bridge.sv
// tb/tb_tlul_axil_master_bridge.sv - scoreboard bench with AXI-lite slave and memory reference model.
module tb_tlul_axil_master_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 8;
`ifdef TLUL_AXIL_BRIDGE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          tl_a_valid_i, tl_a_ready_o;
    logic [2:0]    tl_a_opcode_i;
    logic [1:0]    tl_a_size_i;
    logic [SW-1:0] tl_a_source_i;
    logic [AW-1:0] tl_a_address_i;
    logic [3:0]    tl_a_mask_i;
    logic [DW-1:0] tl_a_data_i;
    logic          tl_d_valid_o, tl_d_ready_i;
    logic [2:0]    tl_d_opcode_o;
    logic [1:0]    tl_d_size_o;
    logic [SW-1:0] tl_d_source_o;
    logic [DW-1:0] tl_d_data_o;
    logic          tl_d_error_o;
    logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]    m_axil_awprot, m_axil_arprot;
    logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [DW-1:0] m_axil_wdata, m_axil_rdata;
    logic [3:0]    m_axil_wstrb;
    logic [1:0]    m_axil_bresp, m_axil_rresp;
    logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic          m_axil_rvalid, m_axil_rready;

    tlul_axil_master_bridge #(
        .axil_data_width_p(DW), .axil_addr_width_p(AW), .tl_source_width_p(SW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tl_a_valid_i(tl_a_valid_i), .tl_a_ready_o(tl_a_ready_o), .tl_a_opcode_i(tl_a_opcode_i),
        .tl_a_size_i(tl_a_size_i), .tl_a_source_i(tl_a_source_i), .tl_a_address_i(tl_a_address_i),
        .tl_a_mask_i(tl_a_mask_i), .tl_a_data_i(tl_a_data_i),
        .tl_d_valid_o(tl_d_valid_o), .tl_d_ready_i(tl_d_ready_i), .tl_d_opcode_o(tl_d_opcode_o),
        .tl_d_size_o(tl_d_size_o), .tl_d_source_o(tl_d_source_o), .tl_d_data_o(tl_d_data_o),
        .tl_d_error_o(tl_d_error_o),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
        .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready)
    );

    typedef struct {
        logic [2:0]    op;
        logic [1:0]    size;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          err;
        bit            illegal;
        int            acc;
        int            lat;
    } d_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
    } wr_exp_t;

    d_exp_t        d_q[$];
    wr_exp_t       wr_q[$];
    logic [AW-1:0] ar_q[$];
    logic [DW-1:0] rmem [logic [AW-1:0]];
    logic [DW-1:0] smem [logic [AW-1:0]];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, exp_aw = 0, exp_ar = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int d_hold_cnt = 0;
    bit cur_illegal = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Slave answers SLVERR for word index 7 of any 64-byte block, OKAY elsewhere.
    function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
        return (a[5:2] == 4'd7) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (!rmem.exists(a)) rmem[a] = init_val(a);
        return rmem[a];
    endfunction

    function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
        if (!smem.exists(a)) smem[a] = init_val(a);
        return smem[a];
    endfunction

    task automatic fail_line(input string what);
        miscompares++;
        $display("FAIL %s at cycle %0d", what, cyc);
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] mask, input logic [SW-1:0] src, input logic [1:0] size,
                        input int awd, input int wd, input int bd, input int ard, input int rd,
                        input int dh);
        int t;
        d_exp_t e;
        logic [3:0] strb;
        logic [DW-1:0] cur;
        t = 0;
        tl_a_opcode_i = op; tl_a_address_i = addr; tl_a_data_i = data;
        tl_a_mask_i = mask; tl_a_source_i = src; tl_a_size_i = size;
        tl_a_valid_i = 1'b1;
        while (!tl_a_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!tl_a_ready_o) begin
            miscompares++;
            $display("FAIL a_accept_timeout: tl_a_ready_o=%b after %0d cycles, required 1", tl_a_ready_o, t);
            tl_a_valid_i = 1'b0;
            return;
        end
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd; d_hold_cnt = dh;
        e.op = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size; e.src = src; e.data = '0; e.acc = cyc;
        e.illegal = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
        e.err = e.illegal;
        if (op == 3'd4) begin
            e.data = ref_read(addr);
            e.err = ERR_EN && (resp_for(addr) != 2'b00);
            e.lat = 3 + ard + rd;
            ar_q.push_back(addr);
            exp_ar++;
        end else if (!e.illegal) begin
            strb = (op == 3'd0) ? 4'hF : mask;
            cur = ref_read(addr);
            for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
            rmem[addr] = cur;
            wr_q.push_back('{addr, data, strb});
            exp_aw++;
            e.err = ERR_EN && (resp_for(addr) != 2'b00);
            e.lat = 3 + ((awd > wd) ? awd : wd) + bd;
        end else begin
            e.lat = 1;
            cur_illegal = 1'b1;
        end
        d_q.push_back(e);
        @(negedge clk);
        tl_a_valid_i = 1'b0;
    endtask

    // AXI-lite slave: readys and responses are set on the falling edge, so a valid&ready
    // seen here is a handshake on the next rising edge.
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_wstrb;
    bit aw_got, w_got, ar_got, b_fire, r_fire;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
            m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (cur_illegal && (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid)) begin
                miscompares++;
                $display("FAIL illegal_axi: awvalid=%b wvalid=%b arvalid=%b, required all 0",
                         m_axil_awvalid, m_axil_wvalid, m_axil_arvalid);
            end
            if (b_fire) begin
                m_axil_bvalid = 1'b0; b_fire = 0; aw_got = 0; w_got = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else if (aw_got && w_got) begin
                if (b_cnt >= b_dly) begin
                    if (!m_axil_bvalid) begin
                        m_axil_bvalid = 1'b1;
                        m_axil_bresp = resp_for(s_awaddr);
                        begin
                            logic [DW-1:0] cur;
                            cur = slv_read(s_awaddr);
                            for (int i = 0; i < 4; i++) if (s_wstrb[i]) cur[8*i +: 8] = s_wdata[8*i +: 8];
                            smem[s_awaddr] = cur;
                        end
                        vectors++;
                        if (wr_q.size() == 0) begin
                            fail_line("axi_write_unexpected");
                        end else begin
                            wr_exp_t w;
                            w = wr_q.pop_front();
                            if (s_awaddr !== w.addr || s_wdata !== w.data || s_wstrb !== w.strb) begin
                                miscompares++;
                                $display("FAIL axi_write: got addr=%h data=%h strb=%b, required addr=%h data=%h strb=%b",
                                         s_awaddr, s_wdata, s_wstrb, w.addr, w.data, w.strb);
                            end
                        end
                    end
                    if (m_axil_bready) b_fire = 1;
                end else begin
                    b_cnt++;
                end
            end
            if (m_axil_awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    m_axil_awready = 1'b1; aw_got = 1; aw_hs++; s_awaddr = m_axil_awaddr;
                    vectors++;
                    if (m_axil_awprot !== 3'b000) begin
                        miscompares++;
                        $display("FAIL awprot: got %b, required 000", m_axil_awprot);
                    end
                end else begin
                    m_axil_awready = 1'b0; aw_cnt++;
                end
            end else begin
                m_axil_awready = 1'b0;
            end
            if (m_axil_wvalid && !w_got) begin
                if (w_cnt >= w_dly) begin
                    m_axil_wready = 1'b1; w_got = 1; w_hs++;
                    s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb;
                end else begin
                    m_axil_wready = 1'b0; w_cnt++;
                end
            end else begin
                m_axil_wready = 1'b0;
            end
            if (r_fire) begin
                m_axil_rvalid = 1'b0; r_fire = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
            end else if (ar_got) begin
                if (r_cnt >= r_dly) begin
                    if (!m_axil_rvalid) begin
                        m_axil_rvalid = 1'b1;
                        m_axil_rdata = slv_read(s_araddr);
                        m_axil_rresp = resp_for(s_araddr);
                    end
                    if (m_axil_rready) r_fire = 1;
                end else begin
                    r_cnt++;
                end
            end
            if (m_axil_arvalid && !ar_got) begin
                if (ar_cnt >= ar_dly) begin
                    logic [AW-1:0] ea;
                    m_axil_arready = 1'b1; ar_got = 1; ar_hs++; s_araddr = m_axil_araddr;
                    vectors++;
                    ea = (ar_q.size() != 0) ? ar_q.pop_front() : 'x;
                    if (m_axil_araddr !== ea || m_axil_arprot !== 3'b000) begin
                        miscompares++;
                        $display("FAIL axi_read: got araddr=%h arprot=%b, required araddr=%h arprot=000",
                                 m_axil_araddr, m_axil_arprot, ea);
                    end
                end else begin
                    m_axil_arready = 1'b0; ar_cnt++;
                end
            end else begin
                m_axil_arready = 1'b0;
            end
        end
    end

    // D-channel monitor: latency on first sight, stability while stalled, full compare on handshake.
    bit d_seen = 0;
    logic [SW+DW+5:0] d_held;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            tl_d_ready_i = 1'b0;
            d_seen = 0;
        end else begin
            if (tl_d_valid_o && tl_a_ready_o) fail_line("one_outstanding: tl_a_ready_o=1 while tl_d_valid_o=1, required 0");
            if (tl_d_valid_o) begin
                if (d_q.size() == 0) begin
                    vectors++;
                    fail_line("d_unexpected: tl_d_valid_o=1, required 0");
                    tl_d_ready_i = 1'b1;
                end else begin
                    d_exp_t e;
                    logic [SW+DW+5:0] now_f;
                    e = d_q[0];
                    now_f = {tl_d_opcode_o, tl_d_size_o, tl_d_source_o, tl_d_data_o, tl_d_error_o};
                    if (!d_seen) begin
                        d_seen = 1;
                        vectors++;
                        if (cyc - e.acc != e.lat) begin
                            miscompares++;
                            $display("FAIL d_latency: got %0d cycles, required %0d", cyc - e.acc, e.lat);
                        end
                    end else begin
                        vectors++;
                        if (now_f !== d_held) begin
                            miscompares++;
                            $display("FAIL d_stable: got %h, required %h", now_f, d_held);
                        end
                    end
                    d_held = now_f;
                    if (d_hold_cnt > 0) begin
                        tl_d_ready_i = 1'b0;
                        d_hold_cnt--;
                    end else begin
                        tl_d_ready_i = ($urandom_range(0, 3) != 0);
                    end
                    if (tl_d_ready_i) begin
                        void'(d_q.pop_front());
                        d_seen = 0;
                        if (e.illegal) cur_illegal = 1'b0;
                        vectors++;
                        if (tl_d_opcode_o !== e.op || tl_d_size_o !== e.size || tl_d_source_o !== e.src ||
                            tl_d_data_o !== e.data || tl_d_error_o !== e.err) begin
                            miscompares++;
                            $display("FAIL d_resp: got op=%0d size=%0d src=%h data=%h err=%b, required op=%0d size=%0d src=%h data=%h err=%b",
                                     tl_d_opcode_o, tl_d_size_o, tl_d_source_o, tl_d_data_o, tl_d_error_o,
                                     e.op, e.size, e.src, e.data, e.err);
                        end
                    end
                end
            end else begin
                tl_d_ready_i = 1'($urandom_range(0, 1));
                d_seen = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string what, input logic a_ready_req);
        vectors++;
        if (tl_a_ready_o !== a_ready_req || tl_d_valid_o !== 1'b0 || m_axil_awvalid !== 1'b0 ||
            m_axil_wvalid !== 1'b0 || m_axil_arvalid !== 1'b0 || m_axil_bready !== 1'b0 ||
            m_axil_rready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: a_ready=%b d_valid=%b aw=%b w=%b ar=%b b_rdy=%b r_rdy=%b, required a_ready=%b others 0",
                     what, tl_a_ready_o, tl_d_valid_o, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                     m_axil_bready, m_axil_rready, a_ready_req);
        end
    endtask

    initial begin
        logic [2:0] ill [5];
        ill = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        tl_a_valid_i = 1'b0; tl_a_opcode_i = '0; tl_a_size_i = '0; tl_a_source_i = '0;
        tl_a_address_i = '0; tl_a_mask_i = '0; tl_a_data_i = '0; tl_d_ready_i = 1'b0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = '0;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0;
        rmem[32'h1000] = 32'hDEAD_BEEF;
        smem[32'h1000] = 32'hDEAD_BEEF;

        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset_state", 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset", 1'b1);

        send(3'd4, 32'h1000, 32'h0, 4'hF, 8'h5A, 2'd2, 0, 0, 0, 0, 0, 0);
        send(3'd1, 32'h0020, 32'h1234_5678, 4'b0011, 8'h11, 2'd2, 0, 0, 0, 0, 0, 0);
        send(3'd0, 32'h1008, 32'hCAFE_F00D, 4'b0000, 8'h22, 2'd2, 3, 0, 1, 0, 0, 0);
        send(3'd4, 32'h101C, 32'h0, 4'hF, 8'h33, 2'd2, 0, 0, 0, 1, 2, 0);
        send(3'd3, 32'h1004, 32'h0, 4'hF, 8'h44, 2'd1, 0, 0, 0, 0, 0, 0);
        send(3'd4, 32'h0020, 32'h0, 4'hF, 8'h55, 2'd2, 0, 0, 0, 0, 0, 5);
        send(3'd1, 32'h1010, 32'hA5A5_0F0F, 4'b1100, 8'h66, 2'd0, 0, 2, 0, 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            logic [2:0] op;
            int r;
            r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd4 : (r < 6) ? 3'd1 : (r < 8) ? 3'd0 : ill[$urandom_range(0, 4)];
            send(op, 32'h1000 + 32'($urandom_range(0, 15)) * 4, $urandom, 4'($urandom),
                 8'($urandom), 2'($urandom_range(0, 2)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1) * 3);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        begin
            int t;
            t = 0;
            while (d_q.size() != 0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            vectors++;
            if (d_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: %0d responses outstanding, required 0", d_q.size());
                d_q.delete();
            end
        end

        send(3'd4, 32'h1030, 32'h0, 4'hF, 8'h77, 2'd2, 0, 0, 0, 0, 20, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        d_q.delete(); wr_q.delete(); ar_q.delete();
        cur_illegal = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid_txn", 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_outputs("after_abandon", 1'b1);

        vectors++;
        if (aw_hs != exp_aw || w_hs != exp_aw || ar_hs != exp_ar) begin
            miscompares++;
            $display("FAIL handshake_count: got aw=%0d w=%0d ar=%0d, required aw=%0d w=%0d ar=%0d",
                     aw_hs, w_hs, ar_hs, exp_aw, exp_aw, exp_ar);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlul_axil_master_bridge.md
TLUL_AXIL_MASTER_BRIDGE -- requirements
Module: tlul_axil_master_bridge

Interface
REQ-001 SHALL have parameter axil_data_width_p, default 32, AXI-lite and TL-UL data width.
REQ-002 SHALL have parameter axil_addr_width_p, default 32, AXI-lite and TL-UL address width.
REQ-003 SHALL have parameter tl_source_width_p, default 8, TL-UL source ID width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have TL-UL A-channel ports:
- tl_a_valid_i, input, 1
- tl_a_ready_o, output, 1
- tl_a_opcode_i, input, 3
- tl_a_size_i, input, 2
- tl_a_source_i, input, tl_source_width_p
- tl_a_address_i, input, axil_addr_width_p
- tl_a_mask_i, input, axil_data_width_p/8
- tl_a_data_i, input, axil_data_width_p
REQ-007 SHALL have TL-UL D-channel ports:
- tl_d_valid_o, output, 1
- tl_d_ready_i, input, 1
- tl_d_opcode_o, output, 3
- tl_d_size_o, output, 2
- tl_d_source_o, output, tl_source_width_p
- tl_d_data_o, output, axil_data_width_p
- tl_d_error_o, output, 1
REQ-008 SHALL have a full AXI-lite master port set, m_axil_*: aw/w/b/ar/r channels with awprot/arprot, wstrb, bresp and rresp, at the parameter widths.

Function
REQ-009 SHALL allow at most one transaction outstanding; tl_a_ready_o is high only in IDLE.
REQ-010 SHALL accept an A beat on tl_a_valid_i&tl_a_ready_o and latch address, data, mask, source, size and opcode into registers.
REQ-011 SHALL map opcode 4 (Get) to an AXI read and opcodes 0/1 (PutFull/PutPartial) to an AXI write; any other opcode skips AXI and responds with tl_d_error_o=1.
REQ-012 SHALL implement states IDLE, WRITE, B_WAIT, READ, R_WAIT, RESP.
- IDLE->WRITE/READ on accept.
- IDLE->RESP on an illegal opcode.
REQ-013 In WRITE, SHALL assert awvalid and wvalid together, drop each independently on its own ready, and go to B_WAIT once both have handshaken (same or different cycles).
REQ-014 SHALL drive wstrb=latched mask; for PutFullData, wstrb SHALL be all ones regardless of mask.
REQ-015 SHALL assert bready only in B_WAIT and go to RESP on bvalid, capturing bresp.
REQ-016 In READ, SHALL assert arvalid until arready, then go to R_WAIT.
REQ-017 SHALL assert rready only in R_WAIT and go to RESP on rvalid, capturing rdata and rresp.
REQ-018 In RESP, SHALL hold tl_d_valid_o=1 with stable fields until tl_d_ready_i, then return to IDLE.
REQ-019 SHALL drive the D-channel fields as follows:
- tl_d_opcode_o: 1 (AccessAckData) for Get, 0 (AccessAck) otherwise.
- tl_d_source_o, tl_d_size_o: the latched values.
- tl_d_data_o: captured rdata for reads, 0 otherwise.
REQ-020 SHALL drive awprot=arprot=3'b000 and awaddr=araddr=latched address unmodified.
REQ-021 SHALL give minimum latency A-accept -> d_valid of 3 cycles with zero-wait AXI slaves, and SHALL have no combinational path from any input to any output.
REQ-022 SHALL ignore bvalid/rvalid arriving outside B_WAIT/R_WAIT.

Reset
REQ-023 SHALL, while rst_ni is low, force state to IDLE and drive all valid/ready outputs to 0, except tl_a_ready_o, which SHALL go high on the first clock after reset release.
REQ-024 SHALL, on reset mid-transaction, abandon the transaction with no D response; latched data registers need not reset.

Configuration
REQ-025 SHALL support macro TLUL_AXIL_BRIDGE_ERR_RESP_EN.
- Defined: tl_d_error_o = (captured resp != 2'b00) | illegal opcode.
- Undefined: bresp/rresp are ignored and tl_d_error_o is 1 only for illegal opcode.

Verification
REQ-026 SHALL cover Get at 0x1000 with the slave returning 0xDEADBEEF with OKAY -> araddr=0x1000; D: opcode=1, data=0xDEADBEEF, error=0, source echoed.
REQ-027 SHALL cover PutPartial addr 0x20, mask 4'b0011, data 0x12345678 -> wstrb=0011, wdata=0x12345678; D: opcode=0, error=0.
REQ-028 SHALL cover a write where awready comes 3 cycles after wready -> exactly one AW and one W handshake, then a single D response.
REQ-029 SHALL cover Get with rresp=SLVERR -> error=1 with the macro defined, error=0 without it.
REQ-030 SHALL cover opcode 3 -> no AXI valid asserted, and D error=1.
REQ-031 SHALL cover tl_d_ready_i held low for 5 cycles, then a back-to-back second A beat -> D fields stable, tl_a_ready_o low until the first D handshake.
